trace_packet_reader: RTL
========================

// Module: trace_packet_reader
// PURPOSE
//  Consumer end of the trace backpressure FIFO. Pops {flag,payload} packets:
//  flag=0 -> trace sample, forwarded downstream on a registered valid/ready port;
//  flag=1 -> loss packet whose payload counts dropped samples, absorbed into
//  statistics and marked on the next forwarded sample via out_gap.
//  Sits between the trace FIFO read side and the trace sink/packetiser.
// PARAMETERS
//  sample_width_p   16  sample payload width; FIFO word is sample_width_p+1 bits
//  counter_width_p  16  loss-count width in loss packets (<= sample_width_p)
//  total_width_p    32  width of the saturating lost-sample total
//  events_width_p   16  width of the saturating loss-event counter
// PORTS
//  clk             in   1                  clock, rising edge
//  rst             in   1                  reset, synchronous, active-high
//  fifo_data       in   sample_width_p+1   [MSB]=loss flag, [sample_width_p-1:0]=payload
//  fifo_valid      in   1                  FIFO head valid
//  fifo_ready      out  1                  pop FIFO head this cycle
//  out_data        out  sample_width_p     forwarded sample
//  out_gap         out  1                  samples were lost immediately before out_data
//  out_valid       out  1                  out_data/out_gap valid
//  out_ready       in   1                  downstream accepts
//  clr_stats       in   1                  clear last_lost/lost_total/loss_events/proto_err
//  last_lost       out  counter_width_p    count from most recent loss packet
//  lost_total      out  total_width_p      saturating sum of loss counts
//  loss_events     out  events_width_p     saturating number of loss packets
//  proto_err       out  1                  sticky: loss packet with count 0 received
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_gap=0, gap_pending=0, all stats=0, proto_err=0.
//  - Accept = fifo_valid & fifo_ready. Loss count = fifo_data[counter_width_p-1:0].
//  - fifo_ready = fifo_valid&flag ? 1 : (~out_valid | out_ready); loss packets never stall.
//  - Output stage: single register. Sample accepted in cycle N -> out_valid in N+1.
//    Full throughput: out_valid&out_ready with new accept reloads same cycle.
//    out_valid held, out_data/out_gap stable while out_valid&~out_ready.
//  - Sample accept: out_data<=payload, out_gap<=gap_pending|loss_this_cycle(n/a), gap_pending<=0.
//  - Loss accept, count!=0: gap_pending<=1; last_lost<=count; lost_total+=count
//    saturating at all-ones; loss_events+=1 saturating. Consecutive loss packets
//    accumulate; single gap mark on next sample.
//  - Loss accept, count==0: proto_err<=1, stats unchanged, gap_pending<=1.
//  - clr_stats same cycle as loss accept: stats take that packet's values only
//    (last_lost=count, lost_total=count, loss_events=1); proto_err cleared unless
//    this packet errs. clr_stats does not touch gap_pending or output stage.
//  - rst mid-stream: output register dropped, gap_pending cleared; FIFO not popped
//    while rst high (fifo_ready=0).
//  - Width: count zero-extended to total_width_p before add; saturation via carry-out.
// STRUCTURE
//  - trace_pkg: localparam loss-flag bit position, typedef trace_word_t (flag+payload),
//    enum {PKT_SAMPLE,PKT_LOSS}, shared with the backpressure writer.
//  - Sub-module sat_accum #(width_p, inc_width_p): clear/add saturating accumulator,
//    clear-plus-add = load; instanced for lost_total and loss_events.
//  - Top: ready logic, output register, gap_pending flag, last_lost/proto_err regs.
// TESTING
//  1 Samples 0x0001,0x0002,0x0003 back-to-back, out_ready=1 -> same data 1 cycle
//    later, out_gap=0, fifo_ready=1 every cycle, no bubbles.
//  2 Sample 0xAAAA, out_ready=0 for 4 cycles, then sample 0xBBBB queued -> out_data
//    holds 0xAAAA, fifo_ready=0 until out_ready=1; then 0xBBBB follows with no loss.
//  3 Loss{5}, loss{3}, sample 0x1234 -> last_lost=3, lost_total=8, loss_events=2,
//    0x1234 emitted with out_gap=1; next sample out_gap=0.
//  4 lost_total preloaded to 0xFFFF_FFFE via loss packets, loss{0xFFFF} -> lost_total=0xFFFF_FFFF, holds.
//  5 Loss{0} -> proto_err=1 sticky, lost_total unchanged; clr_stats with loss{7}
//    same cycle -> lost_total=7, loss_events=1, proto_err=0.
//  6 rst asserted with out_valid=1, gap_pending=1 -> next cycle out_valid=0,
//    fifo_ready=0; after rst first sample has out_gap=0, stats all 0.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: packet format shared by the trace FIFO writer and reader
package trace_pkg;
  localparam int SAMPLE_WIDTH = 16;
  localparam int LOSS_FLAG_BIT = SAMPLE_WIDTH;
  typedef struct packed {
    logic flag;
    logic [SAMPLE_WIDTH-1:0] payload;
  } trace_word_t;
  typedef enum logic {PKT_SAMPLE = 1'b0, PKT_LOSS = 1'b1} pkt_kind_e;
endpackage

// File: rtl/trace_packet_reader_sat_accum.sv
// sat_accum: saturating accumulator; clr clears, clr together with add loads inc
// Ports: clk, rst (sync, active-high), clr, add, inc (zero-extended addend), value
module sat_accum #(
  parameter int width_p = 32,
  parameter int inc_width_p = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   add,
  input  logic [inc_width_p-1:0] inc,
  output logic [width_p-1:0]     value
);
  logic [width_p-1:0] base;
  logic [width_p:0]   sum;
  assign base = clr ? '0 : value;
  assign sum = {1'b0, base} + {{(width_p + 1 - inc_width_p){1'b0}}, inc};
  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else if (add) value <= sum[width_p] ? '1 : sum[width_p-1:0];
    else if (clr) value <= '0;
  end
endmodule

// File: rtl/trace_packet_reader.sv
// trace_packet_reader: pops trace FIFO, forwards samples, folds loss packets into stats
// Ports: clk/rst (sync, active-high); fifo_data/valid/ready FIFO read side;
//   out_data/out_gap/out_valid/out_ready registered downstream port;
//   clr_stats clears last_lost/lost_total/loss_events/proto_err.
module trace_packet_reader
  import trace_pkg::*;
#(
  parameter int sample_width_p = 16,
  parameter int counter_width_p = 16,
  parameter int total_width_p = 32,
  parameter int events_width_p = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [sample_width_p:0]    fifo_data,
  input  logic                       fifo_valid,
  output logic                       fifo_ready,
  output logic [sample_width_p-1:0]  out_data,
  output logic                       out_gap,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clr_stats,
  output logic [counter_width_p-1:0] last_lost,
  output logic [total_width_p-1:0]   lost_total,
  output logic [events_width_p-1:0]  loss_events,
  output logic                       proto_err
);
  pkt_kind_e kind;
  logic [counter_width_p-1:0] count;
  logic accept, samp_acc, loss_acc, good_loss, gap_pending;
  assign kind = fifo_data[sample_width_p] ? PKT_LOSS : PKT_SAMPLE;
  assign count = fifo_data[counter_width_p-1:0];
  // loss packets never touch the output stage, so they are popped regardless of backpressure
  assign fifo_ready = ~rst & ((fifo_valid & kind == PKT_LOSS) | ~out_valid | out_ready);
  assign accept = fifo_valid & fifo_ready;
  assign samp_acc = accept & kind == PKT_SAMPLE;
  assign loss_acc = accept & kind == PKT_LOSS;
  assign good_loss = loss_acc & |count;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_gap <= 1'b0;
      gap_pending <= 1'b0;
    end else begin
      if (samp_acc) begin
        out_valid <= 1'b1;
        out_data <= fifo_data[sample_width_p-1:0];
        out_gap <= gap_pending;
      end else if (out_ready) out_valid <= 1'b0;
      gap_pending <= loss_acc | (gap_pending & ~samp_acc);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lost <= '0;
      proto_err <= 1'b0;
    end else begin
      last_lost <= good_loss ? count : clr_stats ? '0 : last_lost;
      proto_err <= (loss_acc & ~|count) | (proto_err & ~clr_stats);
    end
  end
  sat_accum #(.width_p(total_width_p), .inc_width_p(counter_width_p)) u_total (
    .clk(clk), .rst(rst), .clr(clr_stats), .add(good_loss), .inc(count), .value(lost_total)
  );
  sat_accum #(.width_p(events_width_p), .inc_width_p(1)) u_events (
    .clk(clk), .rst(rst), .clr(clr_stats), .add(good_loss), .inc(1'b1), .value(loss_events)
  );
endmodule
